risc_reg_file: RTL and testbench
================================

// Module: risc_reg_file
// PURPOSE
//  8 x 16-bit general-purpose register file for the 16-bit RISC datapath.
//  Two synchronous read ports (A/B operands) and one synchronous write port (ALU/load result).
//  Sits between decode (register addresses) and execute (operands), with writeback feeding data_result.
//  All state updates on the FALLING edge of clock, so the rising edge is left free for pipeline stages.
// PARAMETERS
//  DATA_W   16  register and data port width
//  ADDR_W   3   register address width; the register count is 2**ADDR_W (8)
// PORTS
//  clock        in   1       single clock; all state updates on negedge
//  reset_n      in   1       asynchronous, active-low reset
//  enable       in   1       stage enable; gates both reads and writes
//  regenable    in   1       write enable; effective only when enable=1
//  readreg1     in   ADDR_W  read address for port A
//  readreg2     in   ADDR_W  read address for port B
//  writereg     in   ADDR_W  write address
//  data_A       out  DATA_W  registered read data, port A
//  data_B       out  DATA_W  registered read data, port B
//  data_result  in   DATA_W  write data
// BEHAVIOUR
//  - Reset: reset_n=0 immediately clears all 8 registers, data_A and data_B to 0, regardless of clock.
//  - Reset release: takes effect on the next negedge after reset_n returns high.
//  - Read: at negedge with enable=1, data_A <= regs[readreg1] and data_B <= regs[readreg2].
//  - Read latency: 1 falling edge; outputs hold between edges.
//  - Write: at negedge with enable=1 and regenable=1, regs[writereg] <= data_result.
//  - enable=0: no read update and no write; data_A/data_B hold their last values; regenable is ignored.
//  - regenable=0 with enable=1: reads proceed; the register array is unchanged.
//  - All registers, including r0, are writable; there is no hard-wired zero register.
//  - Same-edge read/write to the same address without WRITE_BYPASS_EN: the read returns the OLD value.
//    The new value appears on the next enabled negedge.
//  - Identical addresses: readreg1==readreg2 is legal, and both ports return the same value.
//  - Repeated writes: writing the same address on consecutive edges is legal; last write wins.
//  - Address width: exactly 3 bits, so no out-of-range condition exists.
// CONFIGURATION
//  WRITE_BYPASS_EN defined:
//    - Same-edge read/write with enable=1, regenable=1 and readregN==writereg forwards data_result.
//    - The forwarded value lands on the corresponding data_A/data_B at that same negedge (write-first).
//    - Each port is forwarded independently.
//  WRITE_BYPASS_EN undefined: read-old-data as stated in BEHAVIOUR; no forwarding logic is built.
// TESTING
//  Clock period 10 ns, first negedge at 10 ns. Drive inputs mid-high phase (e.g. t=7+10k).
//  1. reset_n=0 then release -> data_A=data_B=0x0000; every register reads 0x0000.
//  2. enable=1, rr1=0, rr2=1, wr=0, data_result=0xFFFF, regenable=1 for one edge:
//       - that edge: data_A=0x0000 (bypass off) or 0xFFFF (WRITE_BYPASS_EN);
//       - next edge: data_A=0xFFFF, data_B=0x0000.
//  3. Write 0x2222 then 0x3333 to r2 on consecutive edges; read r2 -> 0x3333.
//  4. regenable=0, wr=0, data_result=0xFEED for 2 edges -> r0 still 0xFFFF.
//  5. Write 0x4444 to r4, wait >=5 edges, then rr1=rr2=4 -> data_A=data_B=0x4444.
//  6. enable=0 while changing rr1/rr2/wr with regenable=1 -> outputs and array unchanged.
//     Then assert reset_n=0 between edges -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/risc_reg_file.sv
// risc_reg_file: 8 x 16-bit register file for the 16-bit RISC datapath.
// Two registered read ports (A/B) and one write port. All state moves on the
// falling clock edge, which leaves the rising edge free for pipeline stages.
// Optional build macro: WRITE_BYPASS_EN. When it is defined, a same-edge write
// to the address being read is forwarded to that read port (write-first).
// When it is undefined, a same-edge read returns the old register contents.
module risc_reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              regenable,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] data_A,
  output logic [DATA_W-1:0] data_B,
  input  logic [DATA_W-1:0] data_result
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              wr_en;

  // A write happens only when the stage is enabled; regenable alone does nothing
  assign wr_en = enable & regenable;

  // Read-port next values: array contents, optionally overridden by the write in flight
  always_comb begin
    rd_a = regs[readreg1];
    rd_b = regs[readreg2];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (readreg1 == writereg)) rd_a = data_result;
    if (wr_en && (readreg2 == writereg)) rd_b = data_result;
`endif
  end

  // Falling-edge state update with asynchronous active-low clear of array and outputs
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      data_A <= '0;
      data_B <= '0;
    end else if (enable) begin
      data_A <= rd_a;
      data_B <= rd_b;
      if (regenable) regs[writereg] <= data_result;
    end
  end

endmodule

// File: tb/tb_risc_reg_file.sv
// Self-checking bench for risc_reg_file: directed steps followed by random
// traffic, compared against an array-based model of the register file.
module tb_risc_reg_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        regenable;
  logic [2:0]  readreg1, readreg2, writereg;
  logic [15:0] data_A, data_B;
  logic [15:0] data_result;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_regs [8];
  logic [15:0] exp_a, exp_b;

  risc_reg_file dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .regenable  (regenable),
    .readreg1   (readreg1),
    .readreg2   (readreg2),
    .writereg   (writereg),
    .data_A     (data_A),
    .data_B     (data_B),
    .data_result(data_result)
  );

  // 10 ns period; rising edges at 5+10k, falling edges at 10+10k
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
      $error("check %s differs", tag);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    exp_a = 16'h0000;
    exp_b = 16'h0000;
  endtask

  // What one falling edge does, stated directly from the block's rules
  task automatic model_edge();
    if (enable === 1'b1) begin
      exp_a = m_regs[readreg1];
      exp_b = m_regs[readreg2];
`ifdef WRITE_BYPASS_EN
      if (regenable === 1'b1 && readreg1 == writereg) exp_a = data_result;
      if (regenable === 1'b1 && readreg2 == writereg) exp_b = data_result;
`endif
      if (regenable === 1'b1) m_regs[writereg] = data_result;
    end
  endtask

  // One cycle: falling edge, check shortly after, return to the mid-high drive point
  task automatic cyc(input string tag);
    @(negedge clock);
    model_edge();
    #1;
    check({tag, ".A"}, data_A, exp_a);
    check({tag, ".B"}, data_B, exp_b);
    @(posedge clock);
    #2;
  endtask

  // Read every register through both ports without writing
  task automatic read_all(input string tag);
    enable    = 1'b1;
    regenable = 1'b0;
    for (int a = 0; a < 8; a++) begin
      readreg1 = 3'(a);
      readreg2 = 3'(7 - a);
      cyc(tag);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    regenable   = 1'b0;
    readreg1    = '0;
    readreg2    = '0;
    writereg    = '0;
    data_result = '0;
    model_clear();
    #1;
    check("rst.A", data_A, 16'h0000);
    check("rst.B", data_B, 16'h0000);
    #6;                       // t=7, mid-high phase
    reset_n = 1'b1;
    cyc("idle");

    // 1: every register reads zero after reset
    read_all("t1");

    // 2: same-edge write/read of r0
    enable = 1'b1; regenable = 1'b1;
    readreg1 = 3'd0; readreg2 = 3'd1; writereg = 3'd0; data_result = 16'hFFFF;
    cyc("t2w");
`ifdef WRITE_BYPASS_EN
    check("t2.same_edge", data_A, 16'hFFFF);
`else
    check("t2.same_edge", data_A, 16'h0000);
`endif
    regenable = 1'b0;
    cyc("t2r");
    check("t2.next.A", data_A, 16'hFFFF);
    check("t2.next.B", data_B, 16'h0000);

    // 3: back-to-back writes to r2, last wins
    regenable = 1'b1; writereg = 3'd2; data_result = 16'h2222;
    cyc("t3w1");
    data_result = 16'h3333;
    cyc("t3w2");
    regenable = 1'b0; readreg1 = 3'd2;
    cyc("t3r");
    check("t3.r2", data_A, 16'h3333);

    // 4: regenable=0 leaves r0 alone
    writereg = 3'd0; data_result = 16'hFEED;
    cyc("t4a");
    cyc("t4b");
    readreg1 = 3'd0;
    cyc("t4r");
    check("t4.r0", data_A, 16'hFFFF);

    // 5: write r4, let it sit, read on both ports
    regenable = 1'b1; writereg = 3'd4; data_result = 16'h4444;
    cyc("t5w");
    regenable = 1'b0; data_result = 16'h0BAD;
    for (int i = 0; i < 5; i++) cyc("t5idle");
    readreg1 = 3'd4; readreg2 = 3'd4;
    cyc("t5r");
    check("t5.A", data_A, 16'h4444);
    check("t5.B", data_B, 16'h4444);

    // 6: enable=0 freezes outputs and array even with regenable=1
    enable = 1'b0; regenable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      readreg1 = 3'(i); readreg2 = 3'(i + 1); writereg = 3'(i);
      data_result = 16'hA5A0 + 16'(i);
      cyc("t6hold");
      check("t6.holdA", data_A, 16'h4444);
    end
    read_all("t6arr");

    // asynchronous reset in the middle of the high phase
    reset_n = 1'b0;
    #1;
    check("t6.async.A", data_A, 16'h0000);
    check("t6.async.B", data_B, 16'h0000);
    model_clear();
    reset_n = 1'b1;
    enable = 1'b0;
    @(posedge clock); #2;
    read_all("t6post");

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      regenable   = $urandom_range(0, 1) == 1;
      readreg1    = 3'($urandom_range(0, 7));
      readreg2    = ($urandom_range(0, 3) == 0) ? readreg1 : 3'($urandom_range(0, 7));
      writereg    = ($urandom_range(0, 2) == 0) ? readreg1 : 3'($urandom_range(0, 7));
      data_result = 16'($urandom);
      cyc("rnd");
    end
    read_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
